sap_prog_loader: RTL and testbench



---
 rtl/sap_pkg.sv | 31 +++
 rtl/sap_pulse_timer.sv | 28 ++
 rtl/sap_prog_loader.sv | 200 ++++++++++++++++++++
 tb/tb_sap_prog_loader.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared types and constants for the SAP-1 program loader.
// Optional checksum stage is enabled with SAP_PROG_LOADER_CHECKSUM_EN.
package sap_pkg;

  localparam int SAP_RAM_DEPTH = 16;
  localparam int SAP_ADDR_W    = 4;
  localparam int SAP_DATA_W    = 8;
  localparam int TIMER_W       = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_GET_DATA,
    ST_SETUP,
    ST_WRITE,
    ST_GAP,
    ST_GET_CSUM,
    ST_START,
    ST_DONE,
    ST_ERR
  } loader_state_t;

  // Frame length from the low five bits of the length byte: 0 and anything
  // above the RAM depth both mean "fill the whole RAM".
  function automatic logic [4:0] frame_len(input logic [4:0] len_bits);
    if (len_bits == 5'd0 || len_bits > 5'(SAP_RAM_DEPTH)) begin
      return 5'(SAP_RAM_DEPTH);
    end
    return len_bits;
  endfunction

endpackage

// File: rtl/sap_pulse_timer.sv
// Loadable down-counter shared by the loader's WRITE, GAP and START phases.
// Loading value V makes expired assert V cycles later (V = 0: immediately).
module sap_pulse_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_reg;

  // Count down to zero and park there until reloaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign expired = (cnt_reg == '0);

endmodule

// File: rtl/sap_prog_loader.sv
// Byte-stream loader for the SAP-1: takes a length-prefixed frame over a
// valid/ready byte interface, writes RAM 0..N-1 through the external
// programming port, then launches execution.
// Define SAP_PROG_LOADER_CHECKSUM_EN to require a trailing checksum byte.
module sap_prog_loader
  import sap_pkg::*;
#(
  parameter int LOAD_CYCLES  = 5,
  parameter int GAP_CYCLES   = 5,
  parameter int START_CYCLES = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [SAP_ADDR_W-1:0] extaddr,
  output logic [SAP_DATA_W-1:0] extdata,
  output logic                  extload,
  output logic                  extrun,
  output logic                  extauto,
  output logic                  extstart,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [TIMER_W-1:0] LOAD_INIT  = TIMER_W'(LOAD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_INIT   = TIMER_W'(GAP_CYCLES - 1);
  localparam logic [TIMER_W-1:0] START_INIT = TIMER_W'(START_CYCLES - 1);

  loader_state_t   state;
  logic [4:0]      len_reg;
  logic [3:0]      cnt_reg;
  logic            accept;
  logic            last_byte;
  logic            timer_load;
  logic [TIMER_W-1:0] timer_val;
  logic            timer_expired;

  assign accept = in_valid && in_ready;
  // 5-bit compare so a 16-byte frame ends after address 15 without wrapping.
  assign last_byte = (({1'b0, cnt_reg} + 5'd1) == len_reg);

`ifdef SAP_PROG_LOADER_CHECKSUM_EN
  logic [7:0] csum_reg;
  logic [7:0] csum_final;
  assign csum_final = csum_reg + in_data;
`else
  assign err = 1'b0;
`endif

  // Reload the shared timer on entry to each timed phase.
  always_comb begin
    timer_load = 1'b0;
    timer_val  = '0;
    case (state)
      ST_SETUP: begin
        timer_load = 1'b1;
        timer_val  = LOAD_INIT;
      end
      ST_WRITE: begin
        timer_load = timer_expired;
        timer_val  = GAP_INIT;
      end
      ST_GAP: begin
        timer_load = timer_expired;
        timer_val  = START_INIT;
      end
      ST_GET_CSUM: begin
        timer_load = accept;
        timer_val  = START_INIT;
      end
      default: begin
        timer_load = 1'b0;
      end
    endcase
  end

  sap_pulse_timer #(.W(TIMER_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .expired  (timer_expired)
  );

  // Loader FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      in_ready <= 1'b0;
      extaddr  <= '0;
      extdata  <= '0;
      extload  <= 1'b0;
      extrun   <= 1'b0;
      extauto  <= 1'b0;
      extstart <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      len_reg  <= '0;
      cnt_reg  <= '0;
`ifdef SAP_PROG_LOADER_CHECKSUM_EN
      err      <= 1'b0;
      csum_reg <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          in_ready <= 1'b1;
          if (accept) begin
            // Any accepted byte here is the length byte of a new frame.
            len_reg <= frame_len(in_data[4:0]);
            cnt_reg <= '0;
            extrun  <= 1'b0;
            extauto <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b1;
            state   <= ST_GET_DATA;
`ifdef SAP_PROG_LOADER_CHECKSUM_EN
            err      <= 1'b0;
            csum_reg <= in_data;
`endif
          end
        end
        ST_GET_DATA: begin
          if (accept) begin
            extaddr  <= cnt_reg;
            extdata  <= in_data;
            in_ready <= 1'b0;
            state    <= ST_SETUP;
`ifdef SAP_PROG_LOADER_CHECKSUM_EN
            csum_reg <= csum_final;
`endif
          end
        end
        ST_SETUP: begin
          extload <= 1'b1;
          state   <= ST_WRITE;
        end
        ST_WRITE: begin
          if (timer_expired) begin
            extload <= 1'b0;
            state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (timer_expired) begin
            cnt_reg <= cnt_reg + 4'd1;
            if (last_byte) begin
`ifdef SAP_PROG_LOADER_CHECKSUM_EN
              in_ready <= 1'b1;
              state    <= ST_GET_CSUM;
`else
              extrun   <= 1'b1;
              extauto  <= 1'b1;
              extstart <= 1'b1;
              state    <= ST_START;
`endif
            end else begin
              in_ready <= 1'b1;
              state    <= ST_GET_DATA;
            end
          end
        end
`ifdef SAP_PROG_LOADER_CHECKSUM_EN
        ST_GET_CSUM: begin
          if (accept) begin
            if (csum_final == 8'd0) begin
              in_ready <= 1'b0;
              extrun   <= 1'b1;
              extauto  <= 1'b1;
              extstart <= 1'b1;
              state    <= ST_START;
            end else begin
              // Stay ready: the next byte begins a fresh frame.
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= ST_ERR;
            end
          end
        end
`endif
        ST_START: begin
          if (timer_expired) begin
            extstart <= 1'b0;
            done     <= 1'b1;
            busy     <= 1'b0;
            in_ready <= 1'b1;
            state    <= ST_DONE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sap_prog_loader.sv
// Self-checking bench for sap_prog_loader: table-driven frames plus
// hand-written handshake, reset-abort and checksum sequences.
module tb_sap_prog_loader;

  localparam int LC = 5;
  localparam int GC = 5;
  localparam int SC = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] extaddr;
  logic [7:0] extdata;
  logic       extload, extrun, extauto, extstart, busy, done, err;

  always #5 clk = ~clk;

  sap_prog_loader #(
    .LOAD_CYCLES (LC),
    .GAP_CYCLES  (GC),
    .START_CYCLES(SC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .extaddr (extaddr),
    .extdata (extdata),
    .extload (extload),
    .extrun  (extrun),
    .extauto (extauto),
    .extstart(extstart),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  typedef struct {
    logic [7:0]       len;
    logic [15:0][7:0] dat;
    int               n_exp;
  } vec_t;

  vec_t vecs[7];

  int n_vec = 0;
  int n_miss = 0;

  // Write/start monitor state
  int         wr_cnt = 0;
  logic [3:0] wr_addr[64];
  logic [7:0] wr_data[64];
  int         load_w = 0;
  int         start_w = 0;
  int         start_cnt = 0;
  logic       prev_load = 1'b0;
  logic       prev_start = 1'b0;
  logic [3:0] prev_addr = 4'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock, then sample the outputs 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (rst) begin
      prev_load  = 1'b0;
      prev_start = 1'b0;
      load_w     = 0;
      start_w    = 0;
    end else begin
      if (extload && !prev_load) begin
        check("addr_stable_at_rise", {28'd0, extaddr}, {28'd0, prev_addr});
        check("in_ready_low_in_write", {31'd0, in_ready}, 32'd0);
        if (wr_cnt < 64) begin
          wr_addr[wr_cnt] = extaddr;
          wr_data[wr_cnt] = extdata;
        end
        wr_cnt++;
        $display("write addr=%0d data=0x%02h", extaddr, extdata);
      end
      if (extload && prev_load)
        check("addr_stable_in_write", {28'd0, extaddr}, {28'd0, prev_addr});
      if (!extload && prev_load)
        check("extload_width", load_w, LC);
      load_w = extload ? load_w + 1 : 0;
      if (extstart) check("run_auto_in_start", {30'd0, extrun, extauto}, 32'd3);
      if (extstart && !prev_start) start_cnt++;
      if (!extstart && prev_start) check("extstart_width", start_w, SC);
      start_w    = extstart ? start_w + 1 : 0;
      prev_load  = extload;
      prev_start = extstart;
    end
    prev_addr = extaddr;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard    = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && guard < 500) begin
      step();
      guard++;
    end
    if (guard >= 500) check("accept_timeout", 32'd1, 32'd0);
    else step();
    in_valid = 1'b0;
  endtask

  task automatic send_csum(input logic [7:0] sum);
`ifdef SAP_PROG_LOADER_CHECKSUM_EN
    send_byte(8'd0 - sum);
`else
    if (sum == 8'hxx) $display("unused");
`endif
  endtask

  task automatic wait_end();
    int guard;
    guard = 0;
    while (!(done || err) && guard < 3000) begin
      step();
      guard++;
    end
    check("end_timeout", {31'd0, guard < 3000}, 32'd1);
  endtask

  task automatic clear_mon();
    wr_cnt    = 0;
    start_cnt = 0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0] sum;
    clear_mon();
    sum = v.len;
    send_byte(v.len);
    check("new_frame_run_done_low", {29'd0, extrun, extauto, done}, 32'd0);
    check("busy_after_len", {31'd0, busy}, 32'd1);
    for (int i = 0; i < v.n_exp; i++) begin
      send_byte(v.dat[i]);
      sum = sum + v.dat[i];
    end
    send_csum(sum);
    wait_end();
    check("done", {31'd0, done}, 32'd1);
    check("err", {31'd0, err}, 32'd0);
    check("run_auto_held", {30'd0, extrun, extauto}, 32'd3);
    check("busy_idle", {31'd0, busy}, 32'd0);
    check("write_count", wr_cnt, v.n_exp);
    check("start_pulses", start_cnt, 1);
    for (int i = 0; i < v.n_exp && i < wr_cnt; i++) begin
      check("wr_addr", {28'd0, wr_addr[i]}, i);
      check("wr_data", {24'd0, wr_data[i]}, {24'd0, v.dat[i]});
    end
    $display("frame len=0x%02h writes=%0d starts=%0d done=%0d", v.len, wr_cnt, start_cnt, done);
  endtask

  initial begin
    logic [7:0] tog[$];
    logic [7:0] sum;
    int idx, guard;
    logic acc;

    // Stimulus table: length byte, data, expected number of RAM writes.
    for (int k = 0; k < 7; k++) vecs[k].dat = '0;
    vecs[0].len = 8'h04; vecs[0].n_exp = 4;
    vecs[0].dat[0] = 8'h0A; vecs[0].dat[1] = 8'h1B;
    vecs[0].dat[2] = 8'hE0; vecs[0].dat[3] = 8'hF0;
    vecs[1].len = 8'h0C; vecs[1].n_exp = 12;
    vecs[1].dat[0] = 8'h0A; vecs[1].dat[1] = 8'h1B;
    vecs[1].dat[2] = 8'hE0; vecs[1].dat[3] = 8'hF0;
    vecs[1].dat[10] = 8'h01; vecs[1].dat[11] = 8'h02;
    vecs[2].len = 8'h00; vecs[2].n_exp = 16;
    vecs[3].len = 8'h35; vecs[3].n_exp = 16;
    vecs[4].len = 8'h10; vecs[4].n_exp = 16;
    for (int i = 0; i < 16; i++) begin
      vecs[2].dat[i] = 8'(i * 17);
      vecs[3].dat[i] = 8'(8'hC0 + i);
      vecs[4].dat[i] = 8'(8'hFF - i);
    end
    vecs[5].len = 8'hE3; vecs[5].n_exp = 3;
    vecs[5].dat[0] = 8'h55; vecs[5].dat[1] = 8'hAA; vecs[5].dat[2] = 8'h5A;
    vecs[6].len = 8'h01; vecs[6].n_exp = 1;
    vecs[6].dat[0] = 8'h7E;

    // Reset state
    rst = 1'b1;
    step();
    step();
    check("reset_outputs",
          {9'd0, in_ready, extaddr, extdata, extload, extrun, extauto,
           extstart, busy, done, err}, 32'd0);
    rst = 1'b0;
    step();
    check("idle_ready", {31'd0, in_ready}, 32'd1);
    check("idle_busy", {31'd0, busy}, 32'd0);

    for (int k = 0; k < 7; k++) run_vec(vecs[k]);

    // in_valid toggled every other cycle; no byte lost or duplicated.
    clear_mon();
    tog = '{8'h03, 8'h11, 8'h22, 8'h33};
    sum = 8'h03 + 8'h11 + 8'h22 + 8'h33;
`ifdef SAP_PROG_LOADER_CHECKSUM_EN
    tog.push_back(8'd0 - sum);
`endif
    idx = 0;
    guard = 0;
    while (idx < tog.size() && guard < 2000) begin
      in_valid = (guard % 2) == 0;
      in_data  = tog[idx];
      acc      = in_valid && in_ready;
      step();
      if (acc) idx++;
      guard++;
    end
    in_valid = 1'b0;
    check("toggle_all_accepted", idx, tog.size());
    wait_end();
    check("toggle_write_count", wr_cnt, 3);
    for (int i = 0; i < 3 && i < wr_cnt; i++) begin
      check("toggle_addr", {28'd0, wr_addr[i]}, i);
      check("toggle_data", {24'd0, wr_data[i]}, {24'd0, tog[i + 1]});
    end
    check("toggle_done", {31'd0, done}, 32'd1);
    $display("toggle frame writes=%0d done=%0d", wr_cnt, done);

    // Reset during the 3rd WRITE aborts at once; next frame loads normally.
    clear_mon();
    send_byte(8'h05);
    send_byte(8'hA1);
    send_byte(8'hA2);
    send_byte(8'hA3);
    guard = 0;
    while (!(extload && wr_cnt == 3) && guard < 100) begin
      step();
      guard++;
    end
    check("third_write_seen", wr_cnt, 3);
    rst = 1'b1;
    step();
    check("abort_outputs",
          {9'd0, in_ready, extaddr, extdata, extload, extrun, extauto,
           extstart, busy, done, err}, 32'd0);
    rst = 1'b0;
    step();
    $display("reset abort after writes=%0d", wr_cnt);
    run_vec(vecs[0]);

`ifdef SAP_PROG_LOADER_CHECKSUM_EN
    // Good checksum launches, bad checksum errors without a start pulse.
    clear_mon();
    send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'hCE);
    wait_end();
    check("csum_ok_done", {31'd0, done}, 32'd1);
    check("csum_ok_err", {31'd0, err}, 32'd0);
    check("csum_ok_starts", start_cnt, 1);
    $display("csum 0xCE done=%0d err=%0d", done, err);
    clear_mon();
    send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'hCF);
    wait_end();
    check("csum_bad_err", {31'd0, err}, 32'd1);
    check("csum_bad_done", {31'd0, done}, 32'd0);
    check("csum_bad_starts", start_cnt, 0);
    check("csum_bad_run", {30'd0, extrun, extauto}, 32'd0);
    check("csum_bad_ready", {31'd0, in_ready}, 32'd1);
    $display("csum 0xCF done=%0d err=%0d", done, err);
    run_vec(vecs[6]);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
